// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display scanner: index width,
// default refresh divider and the one-hot select helper.
package disp_pkg;

  localparam int DEFAULT_REFRESH_DIV = 100000;

  // Width of an index over n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One bit of a one-hot vector: set when position pos is the selected index.
  function automatic logic onehot_bit(input int idx, input int pos);
    return idx == pos;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Enable-gated modulo-DIV counter; tick_o is high during the last count of
// each period (the advance cycle) and only while en_i is high.
module refresh_prescaler
  import disp_pkg::*;
#(
  parameter int DIV = DEFAULT_REFRESH_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = idx_w(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_scan_mux.sv
// Time-multiplexed multi-digit display scanner with frame snapshot, per-digit
// blanking and frame-start pulse. Optional feature: LEADING_ZERO_BLANK_EN.
module digit_scan_mux
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] value,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  output logic [NUM_DIGITS-1:0]         sel,
  output logic [DIGIT_W-1:0]            digit,
  output logic                          dp,
  output logic [idx_w(NUM_DIGITS)-1:0]  digit_idx,
  output logic                          frame_tick
);

  localparam int IDX_W = idx_w(NUM_DIGITS);
  localparam int VAL_W = NUM_DIGITS * DIGIT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic                  advance;
  logic                  wrap, load;
  logic                  first_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      snap_q, snap_d;
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0] snap_blank_q, snap_blank_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [DIGIT_W-1:0]    digit_q, digit_d;
  logic                  dp_q, dp_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  blank_bit, dp_bit, lit, shown;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .tick_o (advance)
  );

  // Index advance and snapshot capture; first_q forces a load on the edge
  // right after reset so digit 0 shows live data without waiting a frame.
  always_comb begin
    wrap  = advance && (idx_q == LAST_IDX);
    idx_d = idx_q;
    if (advance) idx_d = wrap ? '0 : idx_q + 1'b1;
    load         = wrap || first_q;
    snap_d       = load ? value      : snap_q;
    snap_dp_d    = load ? dp_mask    : snap_dp_q;
    snap_blank_d = load ? blank_mask : snap_blank_q;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd_q, msd_d, msd_new;

  always_comb begin
    msd_new = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (value[i*DIGIT_W +: DIGIT_W] != '0) msd_new = IDX_W'(i);
    end
    msd_d = load ? msd_new : msd_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) msd_q <= '0;
    else        msd_q <= msd_d;
  end

  assign lit = (idx_d <= msd_d);
`else
  assign lit = 1'b1;
`endif

  // Outputs are looked up with the next-state index so they move with idx.
  always_comb begin
    digit_d   = '0;
    blank_bit = 1'b0;
    dp_bit    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        digit_d   = snap_d[i*DIGIT_W +: DIGIT_W];
        blank_bit = snap_blank_d[i];
        dp_bit    = snap_dp_d[i];
      end
    end
    shown = en && !blank_bit && lit;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_d[i] = shown && onehot_bit(int'(idx_d), i);
    end
    dp_d         = dp_bit && shown;
    frame_tick_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q      <= 1'b1;
      idx_q        <= '0;
      snap_q       <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      sel_q        <= NUM_DIGITS'(1);
      digit_q      <= '0;
      dp_q         <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      first_q      <= 1'b0;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      sel_q        <= sel_d;
      digit_q      <= digit_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sel        = sel_q;
  assign digit      = digit_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Randomized and directed bench for digit_scan_mux against a behavioural model
// derived from enabled-cycle counting (honours LEADING_ZERO_BLANK_EN).
module tb_digit_scan_mux;

  localparam int N   = 4;
  localparam int DW  = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [15:0]   value;
  logic [3:0]    dp_mask;
  logic [3:0]    blank_mask;
  logic [3:0]    sel;
  logic [3:0]    digit;
  logic          dp;
  logic [1:0]    digit_idx;
  logic          frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: enabled-edge count since reset plus the frame snapshot.
  int          active;
  bit          m_first;
  logic [15:0] m_snap;
  logic [3:0]  m_dp, m_blank;
  logic [3:0]  e_sel, e_digit;
  logic        e_dp, e_ft;
  int          e_idx;

  digit_scan_mux #(
    .NUM_DIGITS  (N),
    .DIGIT_W     (DW),
    .REFRESH_DIV (DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .value      (value),
    .dp_mask    (dp_mask),
    .blank_mask (blank_mask),
    .sel        (sel),
    .digit      (digit),
    .dp         (dp),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    active  = 0;
    m_first = 1'b1;
    m_snap  = '0;
    m_dp    = '0;
    m_blank = '0;
    e_sel   = 4'b0001;
    e_digit = '0;
    e_dp    = 1'b0;
    e_ft    = 1'b0;
    e_idx   = 0;
  endtask

  task automatic model_edge();
    bit wrap, lit, shown;
    int msd;
    if (en) active++;
    wrap = en && (active % (DIV * N) == 0);
    if (wrap || m_first) begin
      m_snap  = value;
      m_dp    = dp_mask;
      m_blank = blank_mask;
    end
    m_first = 1'b0;
    e_idx   = (active / DIV) % N;
    msd = 0;
    for (int i = 0; i < N; i++) if (((m_snap >> (DW * i)) & 16'hF) != 0) msd = i;
    lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    lit = (e_idx <= msd);
`endif
    shown   = en && !m_blank[e_idx] && lit;
    e_sel   = shown ? 4'(1 << e_idx) : 4'b0000;
    e_dp    = m_dp[e_idx] && shown;
    e_digit = 4'((m_snap >> (DW * e_idx)) & 16'hF);
    e_ft    = wrap;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".sel"},   32'(sel),        32'(e_sel));
    check_eq({tag, ".digit"}, 32'(digit),      32'(e_digit));
    check_eq({tag, ".dp"},    32'(dp),         32'(e_dp));
    check_eq({tag, ".idx"},   32'(digit_idx),  32'(e_idx));
    check_eq({tag, ".ftick"}, 32'(frame_tick), 32'(e_ft));
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  task automatic run_until_idx(input int target);
    for (int i = 0; i < 64 && e_idx != target; i++) step("seek");
    check_eq("seek_idx", 32'(digit_idx), 32'(target));
  endtask

  // Reset asserted between edges must clear the outputs without a clock.
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all({tag, ".async"});
    @(negedge clk);
    check_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    value      = '0;
    dp_mask    = '0;
    blank_mask = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    value = 16'h1234;
    rst_n = 1'b1;

    run("scan", 40);

    run_until_idx(2);
    value = 16'hABCD;
    run("tear", 36);

    blank_mask = 4'b0100;
    dp_mask    = 4'b0110;
    run("mask", 36);
    blank_mask = '0;
    dp_mask    = '0;
    run("unmask", 16);

    run_until_idx(1);
    en = 1'b0;
    run("en_off", 20);
    en = 1'b1;
    run("en_on", 20);

    run_until_idx(3);
    pulse_reset("rst_mid");
    run("after_rst", 20);

    value = 16'h0050;
    run("lzb50", 36);
    value = 16'h0000;
    run("lzb00", 36);

    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) value = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        dp_mask    = 4'($urandom_range(0, 15));
        blank_mask = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
      else step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
